fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 6, meaning the data word width in bits.
REQ-002 The module SHALL have parameter ADDR_SIZE, default 2, meaning the pointer width; depth = 2**ADDR_SIZE words.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write  input  1  push request.
- read  input  1  pop request.
- buff_in  input  DATA_SIZE  push data.
- umb_almost_full  input  ADDR_SIZE+1  almost-full threshold.
- umb_almost_empty  input  ADDR_SIZE+1  almost-empty threshold.
- buffer_out  output  DATA_SIZE  pop data, registered.
- data_count  output  ADDR_SIZE+1  number of stored words.
- fifo_full  output  1  data_count == depth.
- fifo_empty  output  1  data_count == 0.
- almost_full  output  1  data_count >= umb_almost_full.
- almost_empty  output  1  data_count <= umb_almost_empty.
- fifo_pause  output  1  flow-control request to the upstream writer.
- fifo_error  output  1  overflow/underflow indication.

Function
REQ-004 The block SHALL accept a push when write=1 and the FIFO is not full, or when it is full and read=1 in the same cycle: buff_in is written at wr_ptr, and wr_ptr increments modulo depth.
REQ-005 The block SHALL accept a pop when read=1 and fifo_empty=0: buffer_out is loaded with mem[rd_ptr] on that edge (1-cycle latency), and rd_ptr increments modulo depth.
REQ-006 buffer_out SHALL hold its last value in every cycle with no accepted pop.
REQ-007 data_count SHALL be +1 on a push-only cycle, -1 on a pop-only cycle, and unchanged on a push+pop cycle or an idle cycle.
REQ-008 Read and write SHALL both be accepted when full; data_count stays at depth.
REQ-009 When empty with read=1 and write=1, the write SHALL be accepted, the read rejected, and an underflow error raised.
REQ-010 A write while full without read SHALL be dropped (no pointer or memory change) and SHALL raise an overflow error.
REQ-011 A read while empty SHALL be dropped (buffer_out held) and SHALL raise an underflow error.
REQ-012 fifo_full, fifo_empty, almost_full and almost_empty SHALL be combinational decodes of the registered data_count and the threshold inputs.
REQ-013 fifo_pause SHALL be driven by a 2-state FSM. In RUN it is 0 and moves to PAUSE on the next edge when data_count >= umb_almost_full. In PAUSE it is 1 and moves to RUN when data_count <= umb_almost_empty. Output = (state == PAUSE), registered.
REQ-014 Pointer wrap-around SHALL be silent: ADDR_SIZE-bit pointers roll from depth-1 to 0.
REQ-015 Thresholds SHALL be sampled every cycle; a threshold change takes effect on the next FSM evaluation.

Reset
REQ-016 While reset=1 at a rising edge, the block SHALL set wr_ptr, rd_ptr and data_count to 0, buffer_out to 0, the FSM to RUN, and fifo_error to 0; read and write are ignored.
REQ-017 After reset the outputs SHALL read fifo_empty=1, fifo_full=0, fifo_pause=0, and fifo_error=0; memory contents are not cleared.
REQ-018 A reset asserted mid-burst SHALL take priority over any concurrent push or pop.

Configuration
REQ-019 Macro FIFO_ERROR_STICKY_EN SHALL control error persistence. When defined, fifo_error is set by any overflow/underflow and stays 1 until reset. When undefined, fifo_error is a registered 1-cycle pulse in the cycle after each offending request.

Verification
REQ-020 Parameters: DATA_SIZE=6, ADDR_SIZE=3, umb_almost_full=6, umb_almost_empty=3. The bench SHALL cover these scenarios:
- Fill: 8 writes 0x03..0x0A -> data_count 1..8; almost_full at count 6; fifo_pause=1 on the edge after count reaches 6; fifo_full at 8.
- Overflow: a 9th write at full -> data_count stays 8, memory unchanged, fifo_error=1 (sticky; or a 1-cycle pulse without the macro).
- Drain: 8 reads -> buffer_out 0x03..0x0A, each 1 cycle after its read; fifo_pause drops after count reaches 3; fifo_empty at 0.
- Simultaneous: at count 4, read+write with 0x15 for 10 cycles -> count stays 4, pointers wrap, FIFO order preserved, no error.
- Underflow edge: empty with read+write of 0x2A -> count 1, buffer_out unchanged, error raised; next read returns 0x2A.
- Reset: reset at count 5 with write=1 -> count 0, fifo_empty=1, fifo_pause=0, fifo_error=0 on that edge.

Source files
------------

// File: rtl/fifo_param_if.sv
// fifo_param_if: push/pop, threshold and status signals of fifo_param
interface fifo_param_if #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2
);
  logic                 write;
  logic                 read;
  logic [DATA_SIZE-1:0] buff_in;
  logic [ADDR_SIZE:0]   umb_almost_full;
  logic [ADDR_SIZE:0]   umb_almost_empty;
  logic [DATA_SIZE-1:0] buffer_out;
  logic [ADDR_SIZE:0]   data_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 fifo_pause;
  logic                 fifo_error;
  modport master (
    output write, read, buff_in, umb_almost_full, umb_almost_empty,
    input  buffer_out, data_count, fifo_full, fifo_empty, almost_full, almost_empty, fifo_pause, fifo_error
  );
  modport slave (
    input  write, read, buff_in, umb_almost_full, umb_almost_empty,
    output buffer_out, data_count, fifo_full, fifo_empty, almost_full, almost_empty, fifo_pause, fifo_error
  );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with thresholds, pause FSM and error flag (sticky when FIFO_ERROR_STICKY_EN is defined)
module fifo_param #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2
) (
  input logic        clk,
  input logic        reset,
  fifo_param_if.slave bus
);
  typedef enum logic {RUN, PAUSE} state_t;
  state_t               state, state_nx;
  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic                 push, pop, err_ev;
  // count never exceeds depth, so its MSB alone marks full
  assign bus.fifo_full    = bus.data_count[ADDR_SIZE];
  assign bus.fifo_empty   = bus.data_count == '0;
  assign bus.almost_full  = bus.data_count >= bus.umb_almost_full;
  assign bus.almost_empty = bus.data_count <= bus.umb_almost_empty;
  assign bus.fifo_pause   = state == PAUSE;
  assign push   = bus.write && (!bus.fifo_full || bus.read);
  assign pop    = bus.read && !bus.fifo_empty;
  assign err_ev = (bus.write && bus.fifo_full && !bus.read) || (bus.read && bus.fifo_empty);
  always_comb begin
    state_nx = state;
    state_nx = state == RUN ? (bus.almost_full ? PAUSE : RUN) : (bus.almost_empty ? RUN : PAUSE);
  end
  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= bus.buff_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.data_count <= '0;
      bus.buffer_out <= '0;
      bus.fifo_error <= 1'b0;
      state          <= RUN;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        bus.buffer_out <= mem[rd_ptr];
      end
      bus.data_count <= (push && !pop) ? bus.data_count + 1'b1 :
                        (pop && !push) ? bus.data_count - 1'b1 : bus.data_count;
`ifdef FIFO_ERROR_STICKY_EN
      bus.fifo_error <= bus.fifo_error | err_ev;
`else
      bus.fifo_error <= err_ev;
`endif
      state <= state_nx;
    end
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scoreboard bench for fifo_param (DATA_SIZE=6, ADDR_SIZE=3)
module tb_fifo_param;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic acc = 1'b0;
`ifdef FIFO_ERROR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [15:0] act;
  fifo_param_if #(.DATA_SIZE(6), .ADDR_SIZE(3)) bus ();
  fifo_param #(.DATA_SIZE(6), .ADDR_SIZE(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // expected record: out, count, full, empty, almost_full, almost_empty, pause, error
  task automatic step(input logic w, r, rs, input logic [5:0] d, input int cnt,
                      input logic [5:0] out, input logic full, pause, ev, input string nm);
    bus.write   = w;
    bus.read    = r;
    reset       = rs;
    bus.buff_in = d;
    @(posedge clk);
    acc = rs ? 1'b0 : (STICKY ? (acc | ev) : ev);
    q.push_back('{nm, {out, 4'(cnt), full, cnt == 0, cnt >= 6, cnt <= 3, pause, acc}});
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.buffer_out, bus.data_count, bus.fifo_full, bus.fifo_empty,
             bus.almost_full, bus.almost_empty, bus.fifo_pause, bus.fifo_error};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got out=%h cnt=%0d flags=%b want out=%h cnt=%0d flags=%b",
                 e.nm, act[15:10], act[9:6], act[5:0], e.v[15:10], e.v[9:6], e.v[5:0]);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.write = 0;
    bus.read = 0;
    bus.buff_in = 0;
    bus.umb_almost_full = 4'd6;
    bus.umb_almost_empty = 4'd3;
    reset = 1;
    @(negedge clk);
    step(0, 0, 1, 6'h00, 0, 6'h00, 0, 0, 0, "reset0");
    step(0, 0, 1, 6'h00, 0, 6'h00, 0, 0, 0, "reset1");
    for (int k = 1; k <= 8; k++)
      step(1, 0, 0, 6'(2 + k), k, 6'h00, k == 8, k >= 7, 0, $sformatf("fill%0d", k));
    step(1, 0, 0, 6'h3f, 8, 6'h00, 1, 1, 1, "overflow");
    step(0, 0, 0, 6'h00, 8, 6'h00, 1, 1, 0, "after_overflow");
    for (int j = 1; j <= 8; j++)
      step(0, 1, 0, 6'h00, 8 - j, 6'(2 + j), 0, j <= 5, 0, $sformatf("drain%0d", j));
    step(1, 1, 0, 6'h2a, 1, 6'h0a, 0, 0, 1, "underflow_rw");
    step(0, 1, 0, 6'h00, 0, 6'h2a, 0, 0, 0, "read_2a");
    step(0, 1, 0, 6'h00, 0, 6'h2a, 0, 0, 1, "underflow_r");
    for (int k = 1; k <= 4; k++)
      step(1, 0, 0, 6'(k), k, 6'h2a, 0, 0, 0, $sformatf("prefill%0d", k));
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 6'h15, 4, i < 4 ? 6'(i + 1) : 6'h15, 0, 0, 0, $sformatf("simul%0d", i));
    step(0, 1, 0, 6'h00, 3, 6'h15, 0, 0, 0, "pre_reset_rd");
    for (int k = 1; k <= 4; k++)
      step(1, 0, 0, 6'(6'h20 + k), 3 + k, 6'h15, 0, k == 4, 0, $sformatf("refill%0d", k));
    step(0, 1, 0, 6'h00, 6, 6'h15, 0, 1, 0, "pre_reset_rd2");
    step(0, 1, 0, 6'h00, 5, 6'h15, 0, 1, 0, "pre_reset_rd3");
    step(1, 0, 1, 6'h3f, 0, 6'h00, 0, 0, 0, "reset_mid");
    step(1, 0, 0, 6'h11, 1, 6'h00, 0, 0, 0, "post_reset_wr");
    step(0, 1, 0, 6'h00, 0, 6'h11, 0, 0, 0, "post_reset_rd");
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
